// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder and its 4-bit adder slice.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

  // Number of nibbles needed to cover an operand of the given width.
  function automatic int nibble_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/cla_4b.sv
// 4-bit carry look-ahead adder: Sum/Cout = A + B + Cin.
module cla_4b
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                Cin,
  output logic [NIBBLE_W-1:0] Sum,
  output logic                Cout
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  assign g = A & B;
  assign p = A ^ B;

  // Every carry is a flat sum of products of generate/propagate terms.
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign Sum  = p ^ c[NIBBLE_W-1:0];
  assign Cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that streams one nibble per clock through a single cla_4b,
// least-significant nibble first, with valid/ready handshakes on both sides.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             busy
);

  localparam int N     = nibble_count(WIDTH);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  nsa_state_t          state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic                carry_q, carry_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic                cout_q, cout_d;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  assign nib_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign nib_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

  cla_4b u_cla (
    .A   (nib_a),
    .B   (nib_b),
    .Cin (carry_q),
    .Sum (nib_sum),
    .Cout(nib_cout)
  );

  // Next-state and datapath update for the accept / calculate / deliver sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          idx_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d[NIBBLE_W*idx_q +: NIBBLE_W] = nib_sum;
        carry_d = nib_cout;
        idx_d   = idx_q + 1'b1;
        // The output register takes the accumulator including this final nibble.
        if (idx_q == LAST_IDX) begin
          sum_d   = acc_d;
          cout_d  = nib_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      acc_q      <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomised self-checking bench for nibble_serial_adder at WIDTH 16, 32 and 4.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] a, b, sum;
  logic        cin, cout;

  logic        in_valid32, in_ready32, out_valid32, out_ready32, busy32;
  logic [31:0] a32, b32, sum32;
  logic        cin32, cout32;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0]  a4, b4, sum4;
  logic        cin4, cout4;

  int n_checks = 0;
  int n_pass   = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(sum), .Cout(cout), .busy(busy)
  );

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .A(a32), .B(b32), .Cin(cin32), .out_valid(out_valid32), .out_ready(out_ready32),
    .Sum(sum32), .Cout(cout32), .busy(busy32)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(a4), .B(b4), .Cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .Sum(sum4), .Cout(cout4), .busy(busy4)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and wait (bounded) for the accepting edge; in_valid stays high.
  task automatic accept16(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                          input string tag);
    int waited;
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 30) begin
      step();
      waited++;
    end
    if (!in_ready) check_eq({tag, "_accept_timeout"}, 64'd0, 64'd1);
    step();
  endtask

  task automatic wait_result16(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                               input string tag);
    logic [16:0] e;
    int lat;
    bit ready_leak;
    e = 17'(va) + 17'(vb) + 17'(vc);
    lat = 0;
    ready_leak = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready || !busy) ready_leak = 1'b1;
      step();
      lat++;
    end
    if (in_ready) ready_leak = 1'b1;
    check_eq({tag, "_latency"}, 64'(lat), 64'd4);
    check_eq({tag, "_sum"}, 64'(sum), 64'(e[15:0]));
    check_eq({tag, "_cout"}, 64'(cout), 64'(e[16]));
    check_eq({tag, "_ready_while_busy"}, 64'(ready_leak), 64'd0);
  endtask

  task automatic handshake16(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  task automatic op16(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                      input string tag);
    accept16(va, vb, vc, tag);
    in_valid = 1'b0;
    wait_result16(va, vb, vc, tag);
    handshake16(tag);
  endtask

  task automatic run32(input int nops);
    logic [32:0] e;
    int lat;
    int waited;
    for (int i = 0; i < nops; i++) begin
      a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom_range(0, 1));
      e = 33'(a32) + 33'(b32) + 33'(cin32);
      in_valid32 = 1'b1;
      waited = 0;
      while (!in_ready32 && waited < 30) begin step(); waited++; end
      step();
      in_valid32 = 1'b0;
      lat = 0;
      while (!out_valid32 && lat < 40) begin step(); lat++; end
      check_eq("w32_latency", 64'(lat), 64'd8);
      check_eq("w32_sum", 64'(sum32), 64'(e[31:0]));
      check_eq("w32_cout", 64'(cout32), 64'(e[32]));
      out_ready32 = 1'b1;
      step();
      out_ready32 = 1'b0;
    end
  endtask

  task automatic run4(input int nops);
    logic [4:0] e;
    int lat;
    int waited;
    for (int i = 0; i < nops; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom_range(0, 1));
      e = 5'(a4) + 5'(b4) + 5'(cin4);
      in_valid4 = 1'b1;
      waited = 0;
      while (!in_ready4 && waited < 30) begin step(); waited++; end
      step();
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 40) begin step(); lat++; end
      check_eq("w4_latency", 64'(lat), 64'd1);
      check_eq("w4_sum", 64'(sum4), 64'(e[3:0]));
      check_eq("w4_cout", 64'(cout4), 64'(e[4]));
      out_ready4 = 1'b1;
      step();
      out_ready4 = 1'b0;
    end
  endtask

  initial begin
    bit stall_bad;
    bit spurious;
    logic [15:0] ra, rb;
    logic        rc;
    int          gap;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    step();
    step();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_sum", 64'(sum), 64'd0);
    check_eq("rst_cout", 64'(cout), 64'd0);
    rst = 1'b0;
    step();
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    op16(16'h1234, 16'h4321, 1'b0, "basic");
    op16(16'hFFFF, 16'h0000, 1'b1, "ripple");

    // Back-to-back: in_valid stays high, second operands presented right after first accept.
    accept16(16'h0001, 16'h0001, 1'b0, "b2b_first");
    a = 16'h8000; b = 16'h8000; cin = 1'b0;
    wait_result16(16'h0001, 16'h0001, 1'b0, "b2b_first");
    handshake16("b2b_first");
    accept16(16'h8000, 16'h8000, 1'b0, "b2b_second");
    in_valid = 1'b0;
    wait_result16(16'h8000, 16'h8000, 1'b0, "b2b_second");
    handshake16("b2b_second");

    // Stall in DONE for 10 cycles with an upstream request pending.
    accept16(16'hFFFF, 16'hFFFF, 1'b1, "stall");
    in_valid = 1'b0;
    wait_result16(16'hFFFF, 16'hFFFF, 1'b1, "stall");
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
    stall_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!out_valid || in_ready || sum !== 16'hFFFF || cout !== 1'b1) stall_bad = 1'b1;
    end
    in_valid = 1'b0;
    check_eq("stall_stable", 64'(stall_bad), 64'd0);
    handshake16("stall");

    // Reset on the second CALC cycle abandons the operation.
    accept16(16'hABCD, 16'h1111, 1'b0, "abort");
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("abort_sum", 64'(sum), 64'd0);
    check_eq("abort_cout", 64'(cout), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_valid", 64'(out_valid), 64'd0);
    step();
    check_eq("abort_in_ready", 64'(in_ready), 64'd1);
    spurious = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) spurious = 1'b1;
      step();
    end
    check_eq("abort_no_valid", 64'(spurious), 64'd0);
    op16(16'h0F0F, 16'h00F1, 1'b0, "after_abort");

    // Random sweep with random gaps and out_ready raised early.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2);
      for (int j = 0; j < gap; j++) step();
      accept16(ra, rb, rc, "rand");
      in_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      wait_result16(ra, rb, rc, "rand");
      handshake16("rand");
    end

    run32(200);
    run4(200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential wide-operand adder that streams a WIDTH-bit addition through one 4-bit carry look-ahead adder (`cla_4b`), one nibble per clock, least-significant nibble first. It sits directly upstream of `cla_4b`: it slices the operands, feeds each nibble with the registered carry, and collects the nibble sums into a full-width result. It trades latency for area and exposes valid/ready handshakes on both sides so it can be dropped into the adder test environment or a larger datapath.

## Interface
- `WIDTH`, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4 (elaboration error otherwise)
- `clk`  input  1  sole clock, all state updates on rising edge
- `rst`  input  1  synchronous, active-high reset
- `in_valid`  input  1  operands `A`, `B`, `Cin` are valid
- `in_ready`  output  1  block can accept an operation
- `A`  input  WIDTH  operand A
- `B`  input  WIDTH  operand B
- `Cin`  input  1  carry into nibble 0
- `out_valid`  output  1  `Sum`/`Cout` hold a completed result
- `out_ready`  input  1  downstream consumes the result
- `Sum`  output  WIDTH  (A + B + Cin) mod 2^WIDTH
- `Cout`  output  1  bit WIDTH of A + B + Cin
- `busy`  output  1  operation in progress (state ≠ IDLE)

## Operation
- N = WIDTH/4 nibbles; nibble index counter `idx` is $clog2(N) bits (min 1).
- FSM states: IDLE, CALC, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`: latch A, B into operand regs, load carry reg with `Cin`, clear `idx`, go to CALC. Inputs are ignored when `in_ready`=0.
- CALC: `cla_4b` gets A_reg[4*idx +: 4], B_reg[4*idx +: 4], carry reg. Each edge: write the nibble sum into accumulator[4*idx +: 4], carry reg ← `cla_4b` Cout, `idx`++. On the edge where `idx` = N-1: copy the full accumulator (including this nibble) to the `Sum` output reg, final carry to `Cout` reg, go to DONE.
- DONE: `out_valid`=1; `Sum`/`Cout` stable. On `out_ready`, go to IDLE. No new operand is accepted in DONE.
- `Sum`/`Cout` are registered. They keep the last completed result until the next completion and never show partial results.
- Arithmetic is unsigned. Overflow appears only in `Cout`; no saturation.

## Timing
- Reset (`rst`=1 at an edge): state IDLE, `idx`=0, carry reg 0, accumulator 0, `Sum`=0, `Cout`=0, `out_valid`=0, `busy`=0. `in_ready`=0 while `rst` is high, then 1 from the first non-reset cycle.
- Latency: accept at edge k. CALC covers edges k+1…k+N. `out_valid` is high from just after edge k+N (N=4 for WIDTH=16).
- Throughput: at most one operation per N+2 cycles (accept, N CALC, one DONE cycle with `out_ready`=1). `out_ready` held low stalls in DONE indefinitely.
- `out_ready` high before DONE has no effect.
- `in_valid` during CALC/DONE is ignored and not queued. The upstream must hold its request until `in_ready`.
- `rst` mid-CALC or in DONE: the operation is abandoned, no `out_valid` is produced, and all outputs take their reset values at that edge.
- `in_ready`, `out_valid`, `busy` are decoded from state registers only; there is no combinational path from any input.

## Structure
- Shared package `adder_pkg`:
  - `NIBBLE_W` = 4
  - enum `nsa_state_t` {IDLE, CALC, DONE}
- One sub-module instance: existing `cla_4b` (A, B, Cin → Sum, Cout). No other hierarchy.
- Registers: operand A/B, carry, `idx`, accumulator, `Sum`/`Cout` output, state.

## Test plan
- WIDTH=16; A=0x1234, B=0x4321, Cin=0 → out_valid 4 cycles after accept; Sum=0x5555, Cout=0.
- A=0xFFFF, B=0x0000, Cin=1 → carry ripples through all nibbles; Sum=0x0000, Cout=1.
- A=0xFFFF, B=0xFFFF, Cin=1 → Sum=0xFFFF, Cout=1. Hold out_ready=0 for 10 cycles: out_valid and Sum stay stable, in_ready=0 throughout.
- Two requests back-to-back with in_valid held high (0x0001+0x0001, then 0x8000+0x8000) → second accepted only after the first handshake; results 0x0002/0 then 0x0000/1.
- rst pulsed on the 2nd CALC cycle of 0xABCD+0x1111 → no out_valid, Sum=0, Cout=0, in_ready=1 in the cycle after rst drops. A following 0x0F0F+0x00F1, Cin=0 gives 0x1000/0.
- WIDTH=4 and WIDTH=32 builds; random sweep of 1000 ops vs reference A+B+Cin → every result matches; latency = WIDTH/4.
